// File: rtl/host_req_arbiter_if.sv
// NASTI (AXI4-style) channel bundle with 64-bit data.
// The master drives AW/W/AR and the B/R ready signals; the slave drives the rest.
interface nasti_channel #(
  parameter int ID_WIDTH   = 3,
  parameter int USER_WIDTH = 1
);
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [63:0]           aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  aw_lock;
  logic [3:0]            aw_cache;
  logic [2:0]            aw_prot;
  logic [3:0]            aw_qos;
  logic [3:0]            aw_region;
  logic [USER_WIDTH-1:0] aw_user;

  logic                  w_valid;
  logic                  w_ready;
  logic [63:0]           w_data;
  logic [7:0]            w_strb;
  logic                  w_last;
  logic [USER_WIDTH-1:0] w_user;

  logic                  b_valid;
  logic                  b_ready;
  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;
  logic [USER_WIDTH-1:0] b_user;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [63:0]           ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_lock;
  logic [3:0]            ar_cache;
  logic [2:0]            ar_prot;
  logic [3:0]            ar_qos;
  logic [3:0]            ar_region;
  logic [USER_WIDTH-1:0] ar_user;

  logic                  r_valid;
  logic                  r_ready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [63:0]           r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_qos, aw_region, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_prot, ar_qos, ar_region, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_qos, aw_region, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_prot, ar_qos, ar_region, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );
endinterface

// File: rtl/host_req_arbiter.sv
// Round-robin arbiter funnelling N_REQ message requesters onto one NASTI
// write master. One single-beat write (AW -> W -> B) is in flight at a time,
// and each completion is reported back as a one-cycle per-requester pulse.
module host_req_arbiter #(
  parameter int          N_REQ      = 2,
  parameter int          ID_WIDTH   = 3,
  parameter int          USER_WIDTH = 1,
  parameter logic [63:0] HOST_ADDR  = 64'h0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0][15:0] req_id,
  input  logic [N_REQ-1:0][15:0] req_data,
  output logic [N_REQ-1:0]      done_valid,
  output logic                  done_err,
  output logic                  err_sticky,
  nasti_channel.master          nasti
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   last, g_q, win, cand;
  logic            any;
  int              idx;
  logic [15:0]     id_q, data_q;
  logic            grant, b_hs, b_err;

  // Round-robin pick: scan from last+1 upward with wrap; first valid wins.
  always_comb begin
    win  = '0;
    any  = 1'b0;
    idx  = 0;
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx  = (int'(last) + k) % N_REQ;
      cand = GW'(idx);
      if (!any && req_valid[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

  assign grant = (state == S_IDLE) && any;

  // Accept is combinational with the grant; held low while in reset.
  assign req_ready = (grant && rstn) ? (ONE << win) : '0;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: one handshake per phase, B back to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (any)           state_nxt = S_AW;
      S_AW:   if (nasti.aw_ready) state_nxt = S_W;
      S_W:    if (nasti.w_ready)  state_nxt = S_B;
      S_B:    if (nasti.b_valid)  state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner and its message at grant; round-robin pointer follows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last   <= GW'(N_REQ - 1);
      g_q    <= '0;
      id_q   <= '0;
      data_q <= '0;
    end else if (grant) begin
      last   <= win;
      g_q    <= win;
      id_q   <= req_id[win];
      data_q <= req_data[win];
    end
  end

  assign b_hs  = (state == S_B) && nasti.b_valid;
  assign b_err = (nasti.b_resp != 2'b00) || (nasti.b_id != ID_WIDTH'(g_q));

  // Completion pulse and error flags, registered one cycle after B handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_valid <= '0;
      done_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      done_valid <= b_hs ? (ONE << g_q) : '0;
      done_err   <= b_hs && b_err;
      if (b_hs && b_err) err_sticky <= 1'b1;
    end
  end

  // Write address: everything from state and latched registers.
  assign nasti.aw_valid  = (state == S_AW);
  assign nasti.aw_id     = ID_WIDTH'(g_q);
  assign nasti.aw_addr   = HOST_ADDR;
  assign nasti.aw_len    = 8'd0;
  assign nasti.aw_size   = 3'd3;
  assign nasti.aw_burst  = 2'd1;
  assign nasti.aw_lock   = 1'b0;
  assign nasti.aw_cache  = 4'd0;
  assign nasti.aw_prot   = 3'd0;
  assign nasti.aw_qos    = 4'd0;
  assign nasti.aw_region = 4'd0;
  assign nasti.aw_user   = '0;

  // Write data: single beat, message id in the upper half of the low word.
  assign nasti.w_valid = (state == S_W);
  assign nasti.w_data  = {32'h0, id_q, data_q};
  assign nasti.w_strb  = 8'hff;
  assign nasti.w_last  = 1'b1;
  assign nasti.w_user  = '0;

  assign nasti.b_ready = (state == S_B);

  // Read side is never used; R is drained in case the slave ever responds.
  assign nasti.ar_valid  = 1'b0;
  assign nasti.ar_id     = '0;
  assign nasti.ar_addr   = 64'h0;
  assign nasti.ar_len    = 8'd0;
  assign nasti.ar_size   = 3'd0;
  assign nasti.ar_burst  = 2'd0;
  assign nasti.ar_lock   = 1'b0;
  assign nasti.ar_cache  = 4'd0;
  assign nasti.ar_prot   = 3'd0;
  assign nasti.ar_qos    = 4'd0;
  assign nasti.ar_region = 4'd0;
  assign nasti.ar_user   = '0;
  assign nasti.r_ready   = 1'b1;

  logic unused_in;
  assign unused_in = ^{nasti.ar_ready, nasti.r_valid, nasti.r_id, nasti.r_data,
                       nasti.r_resp, nasti.r_last, nasti.r_user, nasti.b_user};

endmodule

// File: tb/tb_host_req_arbiter.sv
// Directed bench for host_req_arbiter with 4 requesters and a scripted slave.
module tb_host_req_arbiter;

  localparam logic [63:0] HADDR = 64'h0000_0000_8000_1000;

  logic clk = 1'b0;
  logic rstn;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][15:0] req_id;
  logic [3:0][15:0] req_data;
  logic [3:0]       done_valid;
  logic             done_err;
  logic             err_sticky;

  logic       aw_rdy, w_rdy, b_vld, bad_id;
  logic [1:0] b_rsp;
  logic [2:0] slv_id = 3'd0;
  int aw_hs = 0;
  int w_hs  = 0;
  int aw0, w0;
  int vecs = 0;
  int errs = 0;

  nasti_channel #(.ID_WIDTH(3), .USER_WIDTH(1)) nasti ();

  host_req_arbiter #(
    .N_REQ(4), .ID_WIDTH(3), .USER_WIDTH(1), .HOST_ADDR(HADDR)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_data(req_data),
    .done_valid(done_valid), .done_err(done_err), .err_sticky(err_sticky),
    .nasti(nasti)
  );

  always #5 clk = ~clk;

  // Scripted slave: ready/valid from the sequence, b_id echoes the last AW id.
  assign nasti.aw_ready = aw_rdy;
  assign nasti.w_ready  = w_rdy;
  assign nasti.b_valid  = b_vld;
  assign nasti.b_resp   = b_rsp;
  assign nasti.b_id     = slv_id ^ (bad_id ? 3'b100 : 3'b000);
  assign nasti.b_user   = 1'b0;
  assign nasti.ar_ready = 1'b0;
  assign nasti.r_valid  = 1'b0;
  assign nasti.r_id     = 3'd0;
  assign nasti.r_data   = 64'h0;
  assign nasti.r_resp   = 2'd0;
  assign nasti.r_last   = 1'b0;
  assign nasti.r_user   = 1'b0;

  // Slave-side bookkeeping: AW id capture and handshake counters.
  always @(posedge clk) begin
    if (nasti.aw_valid && nasti.aw_ready) begin
      slv_id <= nasti.aw_id;
      aw_hs  <= aw_hs + 1;
    end
    if (nasti.w_valid && nasti.w_ready) w_hs <= w_hs + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-wait transaction for a lone requester r, checking the error flags.
  task automatic zw_xact(input int r, input logic exp_err, input logic sticky_pre);
    step();
    req_valid = 4'b0001 << r;
    settle();
    chk("zw_grant", req_ready, 64'(4'b0001 << r));
    step();
    req_valid = 4'b0000;
    settle();
    chk("zw_aw_id", nasti.aw_id, 64'(r));
    step();
    step();
    settle();
    chk("zw_sticky_pre", err_sticky, sticky_pre);
    step();
    settle();
    chk("zw_done", done_valid, 64'(4'b0001 << r));
    chk("zw_done_err", done_err, exp_err);
    chk("zw_sticky", err_sticky, sticky_pre | exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rstn      = 1'b0;
    req_valid = 4'b0001;
    req_id    = '0;
    req_data  = '0;
    req_id[0]   = 16'h0001;
    req_data[0] = 16'h00ab;
    aw_rdy = 1'b1; w_rdy = 1'b1; b_vld = 1'b1; b_rsp = 2'd0; bad_id = 1'b0;

    // Reset state (request pending but must not be accepted).
    #3;
    chk("rst_aw_valid", nasti.aw_valid, 0);
    chk("rst_w_valid", nasti.w_valid, 0);
    chk("rst_b_ready", nasti.b_ready, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_ar_valid", nasti.ar_valid, 0);
    chk("rst_r_ready", nasti.r_ready, 1);
    step();
    step();
    settle();
    chk("rst_hold_req_ready", req_ready, 0);

    // Single request, zero-wait slave: grant in cycle 0, done in cycle 4.
    @(negedge clk);
    rstn = 1'b1;
    settle();
    chk("single_grant", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    settle();
    chk("single_aw_valid", nasti.aw_valid, 1);
    chk("single_aw_id", nasti.aw_id, 0);
    chk("single_aw_addr", nasti.aw_addr, HADDR);
    chk("single_aw_len", nasti.aw_len, 0);
    chk("single_aw_size", nasti.aw_size, 3);
    chk("single_aw_burst", nasti.aw_burst, 1);
    chk("single_w_early", nasti.w_valid, 0);
    step();
    settle();
    chk("single_w_valid", nasti.w_valid, 1);
    chk("single_w_data", nasti.w_data, 64'h0000_0000_0001_00ab);
    chk("single_w_strb", nasti.w_strb, 8'hff);
    chk("single_w_last", nasti.w_last, 1);
    chk("single_aw_drop", nasti.aw_valid, 0);
    step();
    settle();
    chk("single_b_ready", nasti.b_ready, 1);
    chk("single_done_early", done_valid, 0);
    step();
    settle();
    chk("single_done", done_valid, 4'b0001);
    chk("single_done_err", done_err, 0);
    chk("single_b_drop", nasti.b_ready, 0);

    // Fairness from a fresh reset with all four requesters held valid.
    step();
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_id[i]   = 16'h0010 + 16'(i);
      req_data[i] = 16'h00d0 + 16'(i);
    end
    @(negedge clk);
    rstn = 1'b1;
    req_valid = 4'b1111;
    settle();
    for (int k = 0; k < 6; k++) begin
      chk("fair_grant", req_ready, 64'(4'b0001 << (k % 4)));
      step();
      settle();
      chk("fair_aw_valid", nasti.aw_valid, 1);
      chk("fair_aw_id", nasti.aw_id, 64'(k % 4));
      step();
      settle();
      chk("fair_w_data", nasti.w_data, {32'h0, 16'h0010 + 16'(k % 4), 16'h00d0 + 16'(k % 4)});
      step();
      step();
      if (k == 5) req_valid = 4'b0000;
      settle();
      chk("fair_done", done_valid, 64'(4'b0001 << (k % 4)));
    end

    // Backpressure: aw_ready low 5 cycles, then w_ready low 3 cycles.
    step();
    req_valid   = 4'b0100;
    req_id[2]   = 16'h2222;
    req_data[2] = 16'h3333;
    aw_rdy = 1'b0; w_rdy = 1'b0; b_vld = 1'b0;
    aw0 = aw_hs; w0 = w_hs;
    settle();
    chk("bp_grant", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_aw_hold", nasti.aw_valid, 1);
      chk("bp_aw_id", nasti.aw_id, 2);
      chk("bp_aw_addr", nasti.aw_addr, HADDR);
      chk("bp_w_idle", nasti.w_valid, 0);
      step();
    end
    aw_rdy = 1'b1;
    settle();
    chk("bp_aw_hs", nasti.aw_valid, 1);
    step();
    aw_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_w_hold", nasti.w_valid, 1);
      chk("bp_w_data", nasti.w_data, 64'h0000_0000_2222_3333);
      chk("bp_aw_idle", nasti.aw_valid, 0);
      step();
    end
    w_rdy = 1'b1;
    settle();
    chk("bp_w_hs", nasti.w_valid, 1);
    step();
    w_rdy = 1'b0;
    b_vld = 1'b1;
    settle();
    chk("bp_b_ready", nasti.b_ready, 1);
    chk("bp_done_early", done_valid, 0);
    step();
    b_vld = 1'b0;
    settle();
    chk("bp_done", done_valid, 4'b0100);
    chk("bp_aw_count", 64'(aw_hs - aw0), 1);
    chk("bp_w_count", 64'(w_hs - w0), 1);
    aw_rdy = 1'b1; w_rdy = 1'b1; b_vld = 1'b1;

    // Error path: bad resp, then a clean one, then an id mismatch.
    b_rsp = 2'd2;
    zw_xact(0, 1'b1, 1'b0);
    b_rsp = 2'd0;
    zw_xact(1, 1'b0, 1'b1);
    bad_id = 1'b1;
    zw_xact(3, 1'b1, 1'b1);
    bad_id = 1'b0;

    // Reset while in W (last becomes 2 first); requester 0 must win after.
    step();
    req_valid = 4'b0100;
    w_rdy = 1'b0;
    settle();
    chk("mid_grant", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    step();
    step();
    rstn = 1'b0;
    settle();
    chk("mid_aw_valid", nasti.aw_valid, 0);
    chk("mid_w_valid", nasti.w_valid, 0);
    chk("mid_b_ready", nasti.b_ready, 0);
    chk("mid_done", done_valid, 0);
    chk("mid_done_err", done_err, 0);
    chk("mid_sticky", err_sticky, 0);
    req_valid = 4'b0111;
    settle();
    chk("mid_req_gated", req_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    settle();
    chk("mid_regrant", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    w_rdy = 1'b1;
    settle();
    chk("mid_aw_id", nasti.aw_id, 0);
    chk("mid_no_done", done_valid, 0);
    step();
    step();
    step();
    settle();
    chk("mid_done_after", done_valid, 4'b0001);

    // Late request: request 1 waits until the IDLE cycle with done_valid[0].
    step();
    req_valid = 4'b0001;
    settle();
    chk("late_grant0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0010;
    settle();
    chk("late_wait_aw", req_ready, 0);
    step();
    settle();
    chk("late_wait_w", req_ready, 0);
    step();
    settle();
    chk("late_wait_b", req_ready, 0);
    step();
    settle();
    chk("late_done0", done_valid, 4'b0001);
    chk("late_grant1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0000;
    settle();
    chk("late_aw_id", nasti.aw_id, 1);
    step();
    step();
    step();
    settle();
    chk("late_done1", done_valid, 4'b0010);
    chk("late_sticky", err_sticky, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
